median_arbiter: RTL

Shares one MEDIAN core between NREQ independent requesters. Arbitrates round-robin, streams the winner's 9 samples into the core, waits for the core's result strobe, and returns the median to the winner with a one-cycle DONE pulse. A watchdog aborts and resets the core if no result arrives within TIMEOUT cycles. Sits between the requesters (pixel-window builders) and the single MEDIAN instance.

---
 rtl/median_arb_pkg.sv | 25 ++
 rtl/median_arbiter_rr_pick.sv | 42 ++++
 rtl/median_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/median_arb_pkg.sv
// ---------------------------------------------------------------------------
// median_arb_pkg
//   Shared definitions for the median_arbiter slice: arbiter state encoding,
//   number of samples per median window, and the cyclic index helper that
//   the round-robin picker uses.
// ---------------------------------------------------------------------------
package median_arb_pkg;

    localparam int unsigned NSAMPLES = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOAD,
        ST_WAIT,
        ST_RESP,
        ST_ABORT
    } arb_state_t;

    // Next index in 0..n-1, wrapping back to 0 after n-1.
    function automatic int unsigned cyc_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/median_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches i_req upward (cyclic) starting
//   at i_ptr+1 and returns the first set requester.
//
//   i_req     requests, one bit per requester
//   i_ptr     index of the last served requester
//   o_onehot  one-hot winner (zero when no request)
//   o_idx     winner index (zero when no request)
//   o_valid   at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import median_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [PW-1:0]   o_idx,
    output logic            o_valid
);

    logic [PW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = PW'(cyc_next(32'(i_ptr), NREQ));
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
            w_cand = PW'(cyc_next(32'(w_cand), NREQ));
        end
    end

endmodule

// File: rtl/median_arbiter.sv
// ---------------------------------------------------------------------------
// median_arbiter
//   Shares one MEDIAN core between NREQ requesters. Round-robin grant, streams
//   the winner's 9 samples into the core, waits for the result strobe and
//   returns the median with a one-cycle DONE pulse. A watchdog aborts the
//   transaction (and resets the core) if no result arrives within TIMEOUT
//   cycles of WAIT.
//
//   CLK, RST      clock / asynchronous active-high reset
//   REQ, DIN      requester levels and sample buses (requester i at DIN[i*WIDTH +: WIDTH])
//   GNT           one-hot grant, held from GRANT through RESP/ABORT
//   RD            sample consumed from the granted DIN this cycle
//   DONE/RES/ERR  completion pulse, result, timeout flag
//   MED_*         connection to the shared MEDIAN core
// ---------------------------------------------------------------------------
module median_arbiter
    import median_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] DIN,
    output logic [NREQ-1:0]       GNT,
    output logic                  RD,
    output logic [NREQ-1:0]       DONE,
    output logic [WIDTH-1:0]      RES,
    output logic                  ERR,
    output logic [WIDTH-1:0]      MED_DI,
    output logic                  MED_DSI,
    output logic                  MED_nRST,
    input  logic [WIDTH-1:0]      MED_DO,
    input  logic                  MED_DSO
);

    localparam int unsigned   PW     = $clog2(NREQ);
    localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = '1;
    localparam logic [3:0]    C_LAST = 4'(NSAMPLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [PW-1:0]    r_ptr;      // last winner; also the index of the active grant
    logic [3:0]       r_cnt;
    logic [TW-1:0]    r_tmr;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [WIDTH-1:0] r_res;
    logic             r_err;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_load;
    logic [WIDTH-1:0] w_din [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_req    (REQ),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_din[i] = DIN[i*WIDTH +: WIDTH];
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_next = ST_GRANT;
            ST_GRANT: w_next = ST_LOAD;
            ST_LOAD:  if (r_cnt == C_LAST) w_next = ST_WAIT;
            // A result strobe on the last watchdog cycle still wins.
            ST_WAIT: begin
                if (MED_DSO)              w_next = ST_RESP;
                else if (r_tmr == T_LAST) w_next = ST_ABORT;
            end
            ST_RESP:  w_next = ST_IDLE;
            ST_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_load   = (r_state == ST_LOAD);
        RD       = w_load;
        MED_DSI  = w_load;
        MED_DI   = w_load ? w_din[r_ptr] : '0;
        MED_nRST = ~RST & (r_state != ST_ABORT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            r_cnt   <= '0;
            r_tmr   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == ST_IDLE && w_pick_valid) begin
                r_ptr <= w_pick_idx;
                r_gnt <= w_pick_onehot;
            end else if (r_state == ST_RESP || r_state == ST_ABORT) begin
                r_gnt <= '0;
            end

            r_cnt <= w_load ? r_cnt + 4'd1 : '0;

            if (r_state == ST_WAIT) begin
                if (r_tmr != T_MAX) r_tmr <= r_tmr + TW'(1);
            end else begin
                r_tmr <= '0;
            end

            r_done <= (w_next == ST_RESP || w_next == ST_ABORT) ? r_gnt : '0;
            r_err  <= (w_next == ST_ABORT);
            r_res  <= (w_next == ST_RESP) ? MED_DO : '0;
        end
    end

    assign GNT  = r_gnt;
    assign DONE = r_done;
    assign RES  = r_res;
    assign ERR  = r_err;

endmodule
